tpm_wb_regs: RTL
================

# tpm_wb_regs

Wishbone responder exposing the TPM <-> SoC communication registers to the NeoRV32 firmware at 0xF0000000. It synchronizes the LPC-side `exec`/`abort` handshake into the CPU clock domain and snapshots the command descriptor (`op_type`, `locality`, `buf_len`) on each new command. It raises an interrupt on command events and generates the fixed-width `complete` pulse back to the LPC register block. It sits beside the LiteDRAM slaves on the CPU Wishbone bus and is the responder side of the firmware's register accesses.

## Interface
- `BASE_ADDRESS`, 32'hF0000000, region base; match on `wb_adr_i[31:ADDR_WIDTH]`
- `ADDR_WIDTH`, 11, region size is 2^ADDR_WIDTH bytes
- `BUF_WIDTH`, 11, width of `buf_len_i`
- `COMPLETE_PULSE_WIDTH`, 20, `complete_o` high time in cycles (1..255)
- `DEFAULT_READ_VALUE`, 32'hBADFABAC, read data for unmapped offsets

- `clk_i` in 1 CPU/Wishbone clock
- `rst_i` in 1 synchronous, active-high reset
- `wb_adr_i` in 32 byte address
- `wb_dat_i` in 32 write data
- `wb_dat_o` out 32 read data
- `wb_we_i` in 1 write enable
- `wb_sel_i` in 4 byte enables
- `wb_stb_i`, `wb_cyc_i` in 1 strobe, cycle valid
- `wb_ack_o` out 1 transfer acknowledge
- `wb_err_o` out 1 transfer error
- `exec_i`, `abort_i` in 1 asynchronous, from the LPC-domain register block
- `op_type_i` in 4, `locality_i` in 4, `buf_len_i` in BUF_WIDTH: quasi-static, stable while `exec_i` is high
- `complete_o` out 1 command completion pulse to the LPC register block
- `irq_o` out 1 level interrupt to the CPU

## Operation
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `complete_o`=0, `irq_o`=0. All snapshots, EVENT and IRQ_EN clear to 0. Synchronizer flops clear to 0.
- Hit: `hit = cyc & stb & (wb_adr_i[31:ADDR_WIDTH] == BASE_ADDRESS[31:ADDR_WIDTH])`. Register offset is `wb_adr_i[ADDR_WIDTH-1:2]`.
- When not hit, the block drives no ack or err.
- Register map:
  - 0x00 STATUS, RO: `{29'b0, complete_o, abort_s, exec_s}`.
  - 0x04 OP_TYPE, RO: snapshot, zero-extended.
  - 0x08 LOCALITY, RO: snapshot, zero-extended.
  - 0x0C BUF_SIZE, RO: snapshot, zero-extended.
  - 0x10 EVENT, W1C: bit0 `exec` rise, bit1 `abort` rise.
  - 0x14 IRQ_EN, RW, bits[1:0].
  - 0x40 COMPLETE, WO: reads return `{31'b0, complete_o}`.
- Writes to RO offsets are acked and ignored.
- Byte enables: only `wb_sel_i[0]` gates writes, since all writable bits are in byte 0. A write with `sel[0]`=0 is acked with no effect, including at COMPLETE.
- `exec_s`/`abort_s`: 2-flop synchronizers. Edge detect uses a third flop.
- On `exec_s` rise: snapshot `op_type_i`, `locality_i` and `buf_len_i`, and set EVENT[0]. On `abort_s` rise: set EVENT[1].
- Simultaneous W1C clear and new set on the same bit: set wins.
- `irq_o = |(EVENT & IRQ_EN)`, registered.
- COMPLETE counter, 8-bit:
  - A write when the counter is 0 loads `COMPLETE_PULSE_WIDTH`.
  - A write while the counter is nonzero is acked and ignored; it does not retrigger.
  - The counter decrements to 0 each cycle.
  - `complete_o = (counter != 0)`, registered.

## Timing
- Ack: `wb_ack_o` rises the cycle after `hit & ~wb_ack_o`, lasts exactly 1 cycle, and `wb_dat_o` is valid in the same cycle. Back-to-back accesses therefore ack every 2nd cycle.
- `wb_dat_o` returns to 0 the cycle after the ack.
- Write side effects (W1C, IRQ_EN, counter load) commit on the same edge that raises `wb_ack_o`. STATUS reflects `complete_o`=1 from the next access.
- If `cyc`/`stb` drop before the ack, no ack is issued and no side effect occurs, because the decision is registered on the edge with `hit` high.
- `exec_i` change to STATUS visibility: 2 cycles. To snapshot/EVENT update: 3 cycles. To `irq_o`: 4 cycles.
- `complete_o` is high for exactly `COMPLETE_PULSE_WIDTH` cycles, starting the cycle after the write edge.
- Reset mid-transfer: ack, err, counter and `complete_o` drop on the next edge. An in-flight transfer is not acked.

## Configuration
- `TPM_REGS_ERR_EN` defined: accesses to unmapped offsets, and writes to RO offsets, respond with `wb_err_o` for 1 cycle instead of `wb_ack_o`, with `wb_dat_o`=0. Timing is the same as ack.
- Undefined: unmapped accesses are acked and reads return `DEFAULT_READ_VALUE`. `wb_err_o` is tied to 0.

## Test plan
- Reset, then read 0x00 -> ack 1 cycle after stb, data 0x00000000. Read 0x20 -> 0xBADFABAC (macro off) or `wb_err_o` pulse (macro on).
- Set `op_type_i`=4'h3, `locality_i`=4'h2, `buf_len_i`=11'h1A0, then raise `exec_i` -> after 3 cycles, reads of 0x04/0x08/0x0C return 3/2/0x1A0 and EVENT=0x1. With IRQ_EN=1, `irq_o` is high by cycle 4.
- Write 0x1 to 0x10 in the same cycle a new `abort_i` rise arrives at the edge detector -> EVENT=0x2, and the bit0 clear is honored.
- Write 0x40 with `sel`=4'hF -> `complete_o` is high for exactly 20 cycles. A second write at cycle 5 is acked and the pulse length is unchanged. A write with `sel`=4'hE produces no pulse.
- Access to 0xF8000000 -> no ack or err from this block.
- Assert `rst_i` during a pending strobe and mid-pulse -> no ack, `complete_o`=0 next cycle, and IRQ_EN/EVENT read 0 afterwards.

Source files
------------

// File: rtl/tpm_wb_regs.sv
// TPM <-> SoC command registers on the CPU Wishbone bus; optional TPM_REGS_ERR_EN turns bad accesses into wb_err_o.
// Latency: ack/err one cycle after a hit, exec_i -> EVENT in 3 cycles, -> irq_o in 4.
// Backpressure: none; a hit is always answered next cycle, back-to-back accesses every 2nd cycle.
module tpm_wb_regs #(
    parameter logic [31:0] BASE_ADDRESS         = 32'hF0000000,
    parameter int          ADDR_WIDTH           = 11,
    parameter int          BUF_WIDTH            = 11,
    parameter int          COMPLETE_PULSE_WIDTH = 20,
    parameter logic [31:0] DEFAULT_READ_VALUE   = 32'hBADFABAC
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic                 wb_we_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    input  logic                 exec_i,
    input  logic                 abort_i,
    input  logic [3:0]           op_type_i,
    input  logic [3:0]           locality_i,
    input  logic [BUF_WIDTH-1:0] buf_len_i,
    output logic                 complete_o,
    output logic                 irq_o
);

    localparam int OW = ADDR_WIDTH - 2;
    localparam logic [OW-1:0] OFF_STATUS   = OW'(0);
    localparam logic [OW-1:0] OFF_OP_TYPE  = OW'(1);
    localparam logic [OW-1:0] OFF_LOCALITY = OW'(2);
    localparam logic [OW-1:0] OFF_BUF_SIZE = OW'(3);
    localparam logic [OW-1:0] OFF_EVENT    = OW'(4);
    localparam logic [OW-1:0] OFF_IRQ_EN   = OW'(5);
    localparam logic [OW-1:0] OFF_COMPLETE = OW'(16);

    logic                 exec_meta, exec_s, exec_d;
    logic                 abort_meta, abort_s, abort_d;
    logic [3:0]           op_type_q, locality_q;
    logic [BUF_WIDTH-1:0] buf_len_q;
    logic [1:0]           event_q, irq_en_q;
    logic [7:0]           cnt_q;

    logic                 hit, take, wr, bad;
    logic                 mapped, ro;
    logic [OW-1:0]        offset;
    logic [31:0]          rd_dat;
    logic                 exec_rise, abort_rise;
    logic [1:0]           event_clr, event_nxt;
    logic [7:0]           cnt_nxt;

    assign hit    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:ADDR_WIDTH] == BASE_ADDRESS[31:ADDR_WIDTH]);
    assign take   = hit & ~wb_ack_o & ~wb_err_o;
    assign offset = wb_adr_i[ADDR_WIDTH-1:2];
    // All writable bits live in byte 0, so only sel[0] qualifies a write.
    assign wr     = take & wb_we_i & wb_sel_i[0] & ~bad;

    assign exec_rise  = exec_s & ~exec_d;
    assign abort_rise = abort_s & ~abort_d;

    always_comb begin
        rd_dat = DEFAULT_READ_VALUE;
        mapped = 1'b1;
        ro     = 1'b0;
        case (offset)
            OFF_STATUS:   begin rd_dat = {29'b0, complete_o, abort_s, exec_s}; ro = 1'b1; end
            OFF_OP_TYPE:  begin rd_dat = {28'b0, op_type_q};                   ro = 1'b1; end
            OFF_LOCALITY: begin rd_dat = {28'b0, locality_q};                  ro = 1'b1; end
            OFF_BUF_SIZE: begin rd_dat = {{(32-BUF_WIDTH){1'b0}}, buf_len_q};  ro = 1'b1; end
            OFF_EVENT:    rd_dat = {30'b0, event_q};
            OFF_IRQ_EN:   rd_dat = {30'b0, irq_en_q};
            OFF_COMPLETE: rd_dat = {31'b0, complete_o};
            default:      mapped = 1'b0;
        endcase
    end

`ifdef TPM_REGS_ERR_EN
    assign bad = ~mapped | (ro & wb_we_i);
`else
    assign bad = 1'b0;
`endif

    // A new edge-detected set beats a simultaneous W1C clear of the same bit.
    always_comb begin
        event_clr = 2'b00;
        if (wr && offset == OFF_EVENT)
            event_clr = wb_dat_i[1:0];
        event_nxt = (event_q & ~event_clr) | {abort_rise, exec_rise};
    end

    // Writes while a pulse is running are ignored rather than retriggering it.
    always_comb begin
        cnt_nxt = 8'd0;
        if (cnt_q != 8'd0)
            cnt_nxt = cnt_q - 8'd1;
        else if (wr && offset == OFF_COMPLETE)
            cnt_nxt = 8'(COMPLETE_PULSE_WIDTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exec_meta  <= 1'b0;
            exec_s     <= 1'b0;
            exec_d     <= 1'b0;
            abort_meta <= 1'b0;
            abort_s    <= 1'b0;
            abort_d    <= 1'b0;
            op_type_q  <= '0;
            locality_q <= '0;
            buf_len_q  <= '0;
            event_q    <= '0;
            irq_en_q   <= '0;
            cnt_q      <= '0;
            complete_o <= 1'b0;
            irq_o      <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
        end else begin
            exec_meta  <= exec_i;
            exec_s     <= exec_meta;
            exec_d     <= exec_s;
            abort_meta <= abort_i;
            abort_s    <= abort_meta;
            abort_d    <= abort_s;
            if (exec_rise) begin
                op_type_q  <= op_type_i;
                locality_q <= locality_i;
                buf_len_q  <= buf_len_i;
            end
            event_q <= event_nxt;
            if (wr && offset == OFF_IRQ_EN)
                irq_en_q <= wb_dat_i[1:0];
            cnt_q      <= cnt_nxt;
            complete_o <= (cnt_nxt != 8'd0);
            irq_o      <= |(event_q & irq_en_q);
            wb_ack_o   <= take & ~bad;
            wb_err_o   <= take & bad;
            wb_dat_o   <= (take && !wb_we_i && !bad) ? rd_dat : 32'd0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:2], wb_sel_i[3:1], mapped};

endmodule
